seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed 3-digit seven-segment driver that sits directly downstream of the combinational binary-to-BCD encoder. It accepts a 12-bit packed BCD value (hundreds/tens/units) through a load/ready handshake and holds it until a frame boundary, so the display never tears. It scans the digits with a programmable refresh period and a dead-time gap against ghosting, applies leading-zero blanking, and shows a dash for any non-decimal nibble.

## Interface
- CLK_DIV, 50000, clock cycles per digit slot (blank plus on); must satisfy CLK_DIV > BLANK_CYC
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be >= 1
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- bcd_in  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units
- load  in  1  request to capture bcd_in; accepted only when ready=1
- lzb_en  in  1  leading-zero blanking enable; sampled live, not latched
- ready  out  1  high when a new load can be accepted
- an  out  3  digit anodes, active-low: an[0] units, an[1] tens, an[2] hundreds
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}

## Operation
- Registers:
  - shown[11:0]: the displayed value.
  - pending[11:0]: the value waiting for the next frame boundary.
  - pend_v: pending is valid.
  - idx (0..2): current digit.
  - phase: BLANK or ON.
  - cnt: width $clog2(CLK_DIV).
- Reset values: shown=0, pending=0, pend_v=0, idx=0, phase=BLANK, cnt=0, ready=1, an=3'b111, seg=7'b1111111.
- ready = !pend_v, driven from a register.
- Load acceptance: load && ready at a rising edge sets pending=bcd_in and pend_v=1. A load while ready=0 is ignored, with no overwrite.
- FSM transitions:
  - BLANK: cnt counts 0..BLANK_CYC-1. On the last count, go to ON and clear cnt.
  - ON: cnt counts 0..CLK_DIV-BLANK_CYC-1. On the last count, go to BLANK, clear cnt, and advance idx 0→1→2→0.
- Frame boundary: the ON→BLANK transition with idx 2→0. On that edge, if pend_v, then shown=pending and pend_v=0, so ready is 1 from the next cycle.
- Load and boundary on the same edge: if pend_v=0, the new value is captured into pending and shown at the following boundary, not this one.
- Outputs:
  - BLANK phase: an=3'b111 and seg=7'b1111111.
  - ON phase: an has only bit idx low, and seg is the decode of nibble idx of shown.
- Decode (active-low {g..a}):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - 10–15→0111111 (dash)
- Leading-zero blanking (lzb_en=1):
  - Hundreds digit: its anode is held high in its ON slot when its nibble is 0.
  - Tens digit: blanked when both the hundreds and tens nibbles are 0.
  - Units digit: never blanked.
  - A non-decimal nibble is never blanked and breaks the zero run.
- an and seg are registered outputs: they reflect the phase/idx of the previous cycle, a fixed one-cycle lag that applies uniformly.

## Timing
- Slot length is CLK_DIV cycles: BLANK_CYC blank, then CLK_DIV-BLANK_CYC on.
- Frame length is 3*CLK_DIV cycles.
- First ON window after reset deassertion: idx 0, starting BLANK_CYC+1 cycles after the first active edge.
- Load-to-display latency is variable, at most 3*CLK_DIV cycles to the boundary plus BLANK_CYC+1 cycles to the units digit lighting.
- ready falls on the edge after acceptance and rises on the edge after the boundary.
- Reset mid-operation: all registers return to reset values immediately (asynchronously), and any pending value is discarded.

## Structure
- Package seg7_pkg holds:
  - the phase enum (BLANK, ON);
  - localparams for the ten digit patterns, DASH, and ALL_OFF;
  - the anode off pattern.
- One combinational sub-module, bcd_to_seg7 (4-bit nibble in, 7-bit active-low pattern out), instantiated once on the muxed nibble.
- Counter, FSM, handshake and blanking logic stay in the top module.

## Test plan
All scenarios use CLK_DIV=8, BLANK_CYC=2.
- Reset release, no load: the units slot shows seg=1000000 with an=110 for 6 cycles after 2 blank cycles. Tens and hundreds show 1000000 when lzb_en=0 and stay dark when lzb_en=1.
- Load 12'h255 with lzb_en=0: ready drops, then rises after the boundary. In the next frame, the units/tens/hundreds slots show 0010010/0010010/0100100 on an=110/101/011.
- Load 12'h007 with lzb_en=1: an[2] and an[1] stay high in their slots; the units slot shows 1111000. Then load 12'h090: tens shows 0010000, hundreds stays dark, and units shows 1000000.
- Load 12'h0A3: the tens slot shows 0111111 (dash) and units shows 0110000. With lzb_en=1, hundreds stays dark; the tens dash is not blanked.
- Second load 12'h111 while ready=0: it is ignored, and the first value (12'h222) is displayed. A load on the same edge as the boundary with pend_v=0 appears one frame later.
- Assert rst_n low mid-ON slot with pend_v=1: an=111, seg=1111111 and ready=1 immediately. After release, shown=0 and the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constant patterns for the three-digit seven-segment scan driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;
    localparam logic [6:0] SEG_DASH    = 7'b0111111;
    localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;

    localparam logic [2:0] AN_ALL_OFF  = 3'b111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Any non-decimal nibble renders as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed seven-segment driver with frame-synchronous value update,
// per-slot dead time, leading-zero blanking and registered anode/segment outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        lzb_en,
    output logic        ready,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(CLK_DIV - BLANK_CYC - 1);

    phase_t      phase;
    logic [CW-1:0] cnt;
    logic [1:0]  idx;
    logic [11:0] shown;
    logic [11:0] pending;
    logic        pend_v;

    logic        cnt_last;
    logic        frame_end;
    logic        accept;
    logic [3:0]  nibble;
    logic [6:0]  pattern;
    logic        blank_digit;
    logic [2:0]  an_next;
    logic [6:0]  seg_next;

    assign cnt_last  = (phase == PH_BLANK) ? (cnt == BLANK_LAST) : (cnt == ON_LAST);
    assign frame_end = (phase == PH_ON) && cnt_last && (idx == 2'd2);
    assign accept    = load && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= PH_BLANK;
            cnt     <= '0;
            idx     <= 2'd0;
            shown   <= 12'h000;
            pending <= 12'h000;
            pend_v  <= 1'b0;
            ready   <= 1'b1;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                if (phase == PH_BLANK) begin
                    phase <= PH_ON;
                end else begin
                    phase <= PH_BLANK;
                    idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A load accepted on the boundary edge targets the next frame, not this one.
            if (frame_end && pend_v) begin
                shown  <= pending;
                pend_v <= 1'b0;
                ready  <= 1'b1;
            end
            if (accept) begin
                pending <= bcd_in;
                pend_v  <= 1'b1;
                ready   <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = shown[3:0];
        case (idx)
            2'd0:    nibble = shown[3:0];
            2'd1:    nibble = shown[7:4];
            default: nibble = shown[11:8];
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Non-decimal nibbles are nonzero, so they stop the zero run on their own.
    always_comb begin
        blank_digit = 1'b0;
        if (lzb_en) begin
            case (idx)
                2'd2:    blank_digit = (shown[11:8] == 4'd0);
                2'd1:    blank_digit = (shown[11:8] == 4'd0) && (shown[7:4] == 4'd0);
                default: blank_digit = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_next  = AN_ALL_OFF;
        seg_next = SEG_ALL_OFF;
        if (phase == PH_ON && !blank_digit) begin
            seg_next = pattern;
            case (idx)
                2'd0:    an_next = 3'b110;
                2'd1:    an_next = 3'b101;
                default: an_next = 3'b011;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_ALL_OFF;
            seg <= SEG_ALL_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
